// File: rtl/data_io_pkg.sv
// rtl/data_io_pkg.sv - UIO command codes and SPI transfer state shared by the data_io blocks
package data_io_pkg;

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_RX     = 8'h55;
    localparam logic [7:0] CMD_FILE_RX_DAT = 8'h56;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ARG,
        ST_DATA,
        ST_SKIP
    } state_t;

endpackage

// File: rtl/data_io_upload_spi_sync.sv
// rtl/data_io_upload_spi_sync.sv - 2-FF synchronizers for sck/ss/sdi plus sck edge strobes
module spi_sync (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic sdi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_s,
    output logic sdi_s
);

    logic [1:0] sck_ff;
    logic [1:0] ss_ff;
    logic [1:0] sdi_ff;
    logic       sck_d;

    // ss resets to the deselected level so no session starts out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_ff <= 2'b00;
            ss_ff  <= 2'b11;
            sdi_ff <= 2'b00;
            sck_d  <= 1'b0;
        end else begin
            sck_ff <= {sck_ff[0], sck};
            ss_ff  <= {ss_ff[0], ss};
            sdi_ff <= {sdi_ff[0], sdi};
            sck_d  <= sck_ff[1];
        end
    end

    assign sck_rise = sck_ff[1] & ~sck_d;
    assign sck_fall = ~sck_ff[1] & sck_d;
    assign ss_s     = ss_ff[1];
    assign sdi_s    = sdi_ff[1];

endmodule

// File: rtl/data_io_upload.sv
// rtl/data_io_upload.sv - SPI-slave upload path streaming core memory bytes out on sdo
module data_io_upload
    import data_io_pkg::*;
#(
    parameter logic [15:0] START_ADDR      = 16'h0000,
    parameter logic [7:0]  UIO_FILE_RX     = CMD_FILE_RX,
    parameter logic [7:0]  UIO_FILE_RX_DAT = CMD_FILE_RX_DAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        ss,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    output logic        uploading,
    output logic [15:0] addr,
    output logic [13:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_din
);

    logic       sck_rise;
    logic       sck_fall;
    logic       ss_s;
    logic       sdi_s;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] rx;
    logic [7:0] tx;
    logic [7:0] prefetch;
    logic       rd_pend;
    logic [7:0] rx_next;
    logic [3:0] cnt_next;

    spi_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .ss       (ss),
        .sdi      (sdi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_s     (ss_s),
        .sdi_s    (sdi_s)
    );

    // After the command byte the counter cycles 8..15 so bit 3 marks "past the command"
    assign rx_next  = {rx[6:0], sdi_s};
    assign cnt_next = (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rx        <= 8'h00;
            tx        <= 8'h00;
            prefetch  <= 8'h00;
            rd_pend   <= 1'b0;
            addr      <= START_ADDR;
            uploading <= 1'b0;
            mem_rd    <= 1'b0;
            sdo_oe    <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            rd_pend <= mem_rd;
            if (rd_pend) begin
                prefetch <= mem_din;
            end

            // Deselect outranks any edge seen on the same clock
            if (ss_s) begin
                state  <= ST_IDLE;
                cnt    <= 4'd0;
                sdo_oe <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_CMD;
                        cnt   <= 4'd0;
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            rx  <= rx_next;
                            cnt <= cnt_next;
                            if (cnt == 4'd7) begin
                                if (rx_next == UIO_FILE_RX) begin
                                    state <= ST_ARG;
                                end else if (rx_next == UIO_FILE_RX_DAT) begin
                                    state  <= ST_DATA;
                                    sdo_oe <= 1'b1;
                                    mem_rd <= 1'b1;
                                end else begin
                                    state <= ST_SKIP;
                                end
                            end
                        end
                    end
                    ST_ARG: begin
                        if (sck_rise) begin
                            rx  <= rx_next;
                            cnt <= cnt_next;
                            if (cnt == 4'd15) begin
                                state <= ST_SKIP;
                                if (sdi_s) begin
                                    addr      <= START_ADDR;
                                    uploading <= 1'b1;
                                end else begin
                                    uploading <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sck_rise) begin
                            rx  <= rx_next;
                            cnt <= cnt_next;
                        end else if (sck_fall) begin
                            // Byte boundary: hand over the prefetched byte and fetch the next one
                            if (cnt == 4'd8) begin
                                tx     <= prefetch;
                                addr   <= addr + 16'd1;
                                mem_rd <= 1'b1;
                            end else begin
                                tx <= {tx[6:0], 1'b0};
                            end
                        end
                    end
                    ST_SKIP: begin
                        state <= ST_SKIP;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sdo      = tx[7];
    assign mem_addr = addr[13:0];

endmodule

// File: tb/tb_data_io_upload.sv
// tb/tb_data_io_upload.sv - scoreboard bench for data_io_upload with a transaction-level model
module tb_data_io_upload;

    localparam int HALF = 8;
    localparam logic [15:0] START0 = 16'h0000;
    localparam logic [15:0] START1 = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        ss0 = 1'b1;
    logic        ss1 = 1'b1;

    logic        sdo0, sdo_oe0, uploading0, mem_rd0;
    logic [15:0] addr0;
    logic [13:0] mem_addr0;
    logic [7:0]  mem_din0 = 8'h00;
    logic        sdo1, sdo_oe1, uploading1, mem_rd1;
    logic [15:0] addr1;
    logic [13:0] mem_addr1;
    logic [7:0]  mem_din1 = 8'h00;

    logic [7:0]  mem [16384];

    int          n_checks = 0;
    int          n_fail = 0;

    logic [7:0]  exp_bytes[$];
    logic [13:0] rdq0[$];
    logic [13:0] rdq1[$];
    logic [15:0] maddr[2];
    logic        mup[2];

    int          sel = 0;
    logic        cur_dat = 1'b0;
    int          bit_idx = 0;
    int          nacc = 0;
    logic [7:0]  acc = 8'h00;

    logic        ss_m, sdo_m, oe_m;
    assign ss_m  = (sel == 1) ? ss1 : ss0;
    assign sdo_m = (sel == 1) ? sdo1 : sdo0;
    assign oe_m  = (sel == 1) ? sdo_oe1 : sdo_oe0;

    always #5 clk = ~clk;

    data_io_upload #(.START_ADDR(START0)) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .ss        (ss0),
        .sdi       (sdi),
        .sdo       (sdo0),
        .sdo_oe    (sdo_oe0),
        .uploading (uploading0),
        .addr      (addr0),
        .mem_addr  (mem_addr0),
        .mem_rd    (mem_rd0),
        .mem_din   (mem_din0)
    );

    data_io_upload #(.START_ADDR(START1)) dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .ss        (ss1),
        .sdi       (sdi),
        .sdo       (sdo1),
        .sdo_oe    (sdo_oe1),
        .uploading (uploading1),
        .addr      (addr1),
        .mem_addr  (mem_addr1),
        .mem_rd    (mem_rd1),
        .mem_din   (mem_din1)
    );

    always @(posedge clk) begin
        if (mem_rd0) mem_din0 <= mem[mem_addr0];
        if (mem_rd1) mem_din1 <= mem[mem_addr1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read-strobe monitor: every mem_rd must match the next expected address
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd0) begin
                if (rdq0.size() == 0) check("unexpected mem_rd dut", 1, 0);
                else check("mem_addr dut", {18'd0, mem_addr0}, {18'd0, rdq0.pop_front()});
            end
            if (mem_rd1) begin
                if (rdq1.size() == 0) check("unexpected mem_rd dut_wrap", 1, 0);
                else check("mem_addr dut_wrap", {18'd0, mem_addr1}, {18'd0, rdq1.pop_front()});
            end
        end
    end

    // MISO monitor: sdo sampled where the io controller samples it, on the sck rise
    always @(posedge sck) begin
        if (!ss_m) begin
            check("sdo_oe", {31'd0, oe_m}, {31'd0, (bit_idx >= 8) && cur_dat});
            if (oe_m) begin
                acc = {acc[6:0], sdo_m};
                nacc++;
                if (nacc == 8) begin
                    if (exp_bytes.size() == 0) check("unexpected miso byte", {24'd0, acc}, 32'hFFFF_FFFF);
                    else check("miso byte", {24'd0, acc}, {24'd0, exp_bytes.pop_front()});
                    nacc = 0;
                end
            end
            bit_idx++;
        end
    end

    always @(posedge ss_m) begin
        bit_idx = 0;
        nacc = 0;
    end

    task automatic drive_ss(input int inst, input logic v);
        if (inst == 1) ss1 = v;
        else ss0 = v;
    endtask

    // One SPI bit in mode 0; on the last bit sck falls together with the deselect
    task automatic spi_bit(input int inst, input logic b, input logic last);
        sdi = b;
        clks(HALF);
        sck = 1'b1;
        clks(HALF);
        sck = 1'b0;
        if (last) drive_ss(inst, 1'b1);
    endtask

    task automatic model_txn(input int inst, input logic [7:0] cmd, input logic [7:0] arg, input int nbits);
        logic [15:0] a;
        logic [15:0] start;
        int          loads;
        start = (inst == 1) ? START1 : START0;
        a = maddr[inst];
        if (cmd == 8'h55 && nbits >= 8) begin
            mup[inst] = arg[0];
            if (arg[0]) maddr[inst] = start;
        end else if (cmd == 8'h56) begin
            if (inst == 1) rdq1.push_back(a[13:0]);
            else rdq0.push_back(a[13:0]);
            loads = (nbits + 7) / 8;
            for (int k = 0; k < loads; k++) begin
                a = a + 16'd1;
                if (inst == 1) rdq1.push_back(a[13:0]);
                else rdq0.push_back(a[13:0]);
            end
            for (int k = 0; k < nbits / 8; k++) begin
                logic [15:0] ba;
                ba = maddr[inst] + 16'(k);
                exp_bytes.push_back(mem[ba[13:0]]);
            end
            maddr[inst] = a;
        end
    endtask

    task automatic spi_txn(input int inst, input logic [7:0] cmd, input logic [7:0] arg, input int nbits);
        int total;
        model_txn(inst, cmd, arg, nbits);
        sel = inst;
        cur_dat = (cmd == 8'h56);
        total = 8 + nbits;
        drive_ss(inst, 1'b0);
        clks(8);
        for (int i = 0; i < total; i++) begin
            logic b;
            b = (i < 8) ? cmd[7 - i] : arg[7 - ((i - 8) % 8)];
            spi_bit(inst, b, i == total - 1);
        end
        clks(8);
    endtask

    task automatic check_state0(input string tag);
        check({tag, " addr"}, {16'd0, addr0}, {16'd0, maddr[0]});
        check({tag, " uploading"}, {31'd0, uploading0}, {31'd0, mup[0]});
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        mem[2] = 8'hFF;
        maddr[0] = START0;
        maddr[1] = START1;
        mup[0] = 1'b0;
        mup[1] = 1'b0;

        clks(4);
        reset = 1'b0;
        clks(1);
        check("reset sdo", {31'd0, sdo0}, 0);
        check("reset sdo_oe", {31'd0, sdo_oe0}, 0);
        check("reset uploading", {31'd0, uploading0}, 0);
        check("reset addr", {16'd0, addr0}, {16'd0, START0});
        check("reset mem_rd", {31'd0, mem_rd0}, 0);
        check("reset addr wrap", {16'd0, addr1}, {16'd0, START1});
        clks(4);

        spi_txn(0, 8'h55, 8'h01, 8);
        check_state0("open");
        check("open uploading", {31'd0, uploading0}, 1);

        spi_txn(0, 8'h56, 8'h00, 24);
        check("stream addr", {16'd0, addr0}, 3);
        check("stream uploading", {31'd0, uploading0}, 1);

        spi_txn(0, 8'h56, 8'h00, 8);
        check_state0("resume");

        spi_txn(0, 8'h55, 8'h00, 8);
        check_state0("close");
        check("close uploading", {31'd0, uploading0}, 0);

        spi_txn(0, 8'h53, 8'hA7, 16);
        check_state0("unknown");

        spi_txn(0, 8'h56, 8'h5A, 12);
        check_state0("abort");
        spi_txn(0, 8'h56, 8'h00, 8);
        check_state0("after abort");

        for (int r = 0; r < 12; r++) begin
            int          kind;
            logic [7:0]  c;
            logic [7:0]  unk [4];
            unk[0] = 8'h53;
            unk[1] = 8'h54;
            unk[2] = 8'h00;
            unk[3] = 8'hFF;
            kind = $urandom_range(0, 3);
            if (kind == 0) spi_txn(0, 8'h55, 8'($urandom), 8);
            else if (kind == 3) begin
                c = unk[$urandom_range(0, 3)];
                spi_txn(0, c, 8'($urandom), $urandom_range(0, 16));
            end else spi_txn(0, 8'h56, 8'($urandom), $urandom_range(0, 20));
            check_state0("random");
        end

        // Reset in the middle of a data byte
        check("pre-reset reads drained", rdq0.size(), 0);
        model_txn(0, 8'h56, 8'h00, 4);
        sel = 0;
        cur_dat = 1'b1;
        ss0 = 1'b0;
        clks(8);
        for (int i = 0; i < 12; i++) spi_bit(0, (i < 8) ? ((8'h56 >> (7 - i)) & 1) != 0 : 1'b1, 1'b0);
        clks(HALF);
        check("mid-data reads drained", rdq0.size(), 0);
        reset = 1'b1;
        clks(1);
        check("mid reset sdo", {31'd0, sdo0}, 0);
        check("mid reset sdo_oe", {31'd0, sdo_oe0}, 0);
        check("mid reset uploading", {31'd0, uploading0}, 0);
        check("mid reset addr", {16'd0, addr0}, {16'd0, START0});
        check("mid reset mem_addr", {18'd0, mem_addr0}, {18'd0, START0[13:0]});
        check("mid reset mem_rd", {31'd0, mem_rd0}, 0);
        reset = 1'b0;
        ss0 = 1'b1;
        maddr[0] = START0;
        mup[0] = 1'b0;
        maddr[1] = START1;
        mup[1] = 1'b0;
        exp_bytes.delete();
        clks(8);
        spi_txn(0, 8'h56, 8'h00, 8);
        check_state0("post reset");

        spi_txn(1, 8'h55, 8'h01, 8);
        spi_txn(1, 8'h56, 8'h00, 8);
        check("wrap addr", {16'd0, addr1}, 0);
        check("wrap mem_addr", {18'd0, mem_addr1}, 0);
        check("wrap uploading", {31'd0, uploading1}, 1);

        clks(4);
        check("expected bytes drained", exp_bytes.size(), 0);
        check("expected reads dut drained", rdq0.size(), 0);
        check("expected reads dut_wrap drained", rdq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
